// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result bus of the sequential ALU.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. The issuer holds in_valid/a/b/op until that edge; the ALU holds
// out_valid/y/y_hi/flags/err stable until the edge where out_ready is seen.
// Neither side may make valid depend combinationally on ready.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_hi;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;
    logic             err;

    // Issue stage / writeback stage side.
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, y_hi, flag_z, flag_c, flag_v, flag_n, err
    );

    // ALU side.
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, y_hi, flag_z, flag_c, flag_v, flag_n, err
    );
endinterface

// File: rtl/alu_div_iter.sv
// Restoring shift-subtract divider, one quotient bit per clock, WIDTH clocks.
// quotient/remainder show the result of the step being taken this cycle, so
// they carry the final answer during the cycle where done is 1.
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next, quo_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, div_q};
        fits     = ~trial[WIDTH];
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], fits};
    end

    // Load operands on start, then iterate until the bit counter runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= a;
            div_q  <= b;
            cnt    <= CW'(WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt - 1'b1;
            if (cnt == CW'(1)) busy_q <= 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt == CW'(1));
    assign quotient  = quo_next;
    assign remainder = rem_next;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, full-width multiply and an
// iterative divider. Results and flags only change on entry to DONE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus,
    output state_t    dbg_state
);
    state_t state;

    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   r_y, r_hi;
    logic               r_z, r_c, r_v, r_n, r_err;
    logic               div_start, div_busy, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign dbg_state     = state;
    assign div_start     = (state == ST_IDLE) && bus.in_valid &&
                           (bus.op == OP_DIV) && (bus.b != '0);

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .a         (bus.a),
        .b         (bus.b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Single-cycle result and flags for the operation on the bus.
    always_comb begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        diff  = {1'b0, bus.a} - {1'b0, bus.b};
        prod  = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
        r_y   = '0;
        r_hi  = '0;
        r_c   = 1'b0;
        r_v   = 1'b0;
        r_err = 1'b0;
        case (bus.op)
            OP_ADD: begin
                r_y = sum[WIDTH-1:0];
                r_c = sum[WIDTH];
                r_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                r_y = diff[WIDTH-1:0];
                r_c = diff[WIDTH];
                r_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MUL: begin
                r_y  = prod[WIDTH-1:0];
                r_hi = prod[2*WIDTH-1:WIDTH];
                r_c  = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                // Only reaches the output registers when b is zero.
                r_y   = '1;
                r_hi  = bus.a;
                r_err = 1'b1;
            end
            OP_AND:  r_y = bus.a & bus.b;
            OP_OR:   r_y = bus.a | bus.b;
            OP_NOT:  r_y = ~bus.a;
            default: r_y = bus.a ^ bus.b;
        endcase
        r_z = (r_y == '0) && !r_err;
        r_n = r_y[WIDTH-1] && !r_err;
    end

    // Handshake FSM with registered result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bus.y      <= '0;
            bus.y_hi   <= '0;
            bus.flag_z <= 1'b0;
            bus.flag_c <= 1'b0;
            bus.flag_v <= 1'b0;
            bus.flag_n <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_start) begin
                        state <= ST_DIV;
                    end else if (bus.in_valid) begin
                        state      <= ST_DONE;
                        bus.y      <= r_y;
                        bus.y_hi   <= r_hi;
                        bus.flag_z <= r_z;
                        bus.flag_c <= r_c;
                        bus.flag_v <= r_v;
                        bus.flag_n <= r_n;
                        bus.err    <= r_err;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state      <= ST_DONE;
                        bus.y      <= div_quo;
                        bus.y_hi   <= div_rem;
                        bus.flag_z <= (div_quo == '0);
                        bus.flag_c <= 1'b0;
                        bus.flag_v <= 1'b0;
                        bus.flag_n <= div_quo[WIDTH-1];
                        bus.err    <= 1'b0;
                    end else if (!div_busy) begin
                        // Divider idle without finishing: never expected, recover.
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expected values.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;
    int     checks = 0;
    int     failures = 0;
    logic [W-1:0] exp_q[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    // Drivers.
    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.op       = OP_ADD;
    endtask

    // Present one operation for one edge; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input int limit, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < limit) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.y !== 8'h00 || bus.y_hi !== 8'h00) begin failures++; $display("FAIL rst_y got=%0h/%0h exp=0/0", bus.y, bus.y_hi); end
        checks++; if ({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n, bus.err} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n, bus.err}); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_release got rdy=%0b vld=%0b exp rdy=1 vld=0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_add();
        issue(OP_ADD, 8'd200, 8'd100);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.y !== 8'd44 || bus.y_hi !== 8'd0) begin failures++; $display("FAIL add_y got=%0d/%0d exp=44/0", bus.y, bus.y_hi); end
        checks++; if ({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n, bus.err} !== 5'b01000) begin failures++; $display("FAIL add_flags got=%b exp=01000", {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n, bus.err}); end
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL add_one_cycle got vld=%0b rdy=%0b exp vld=0 rdy=1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.y !== 8'd44) begin failures++; $display("FAIL add_hold_y got=%0d exp=44", bus.y); end
        issue(OP_ADD, 8'h7F, 8'h01);
        checks++; if (bus.y !== 8'h80 || {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n} !== 4'b0011) begin failures++; $display("FAIL add_ovf got y=%0h f=%b exp y=80 f=0011", bus.y, {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}); end
        step();
    endtask

    task automatic test_sub();
        issue(OP_SUB, 8'd5, 8'd7);
        checks++; if (bus.y !== 8'd254 || {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n} !== 4'b0101) begin failures++; $display("FAIL sub_borrow got y=%0d f=%b exp y=254 f=0101", bus.y, {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}); end
        step();
        issue(OP_SUB, 8'h80, 8'h01);
        checks++; if (bus.y !== 8'h7F || {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n} !== 4'b0010) begin failures++; $display("FAIL sub_ovf got y=%0h f=%b exp y=7f f=0010", bus.y, {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}); end
        step();
    endtask

    task automatic test_mul();
        issue(OP_MUL, 8'd20, 8'd15);
        checks++; if (bus.y !== 8'd44 || bus.y_hi !== 8'd1 || bus.flag_c !== 1'b1) begin failures++; $display("FAIL mul_300 got y=%0d hi=%0d c=%0b exp y=44 hi=1 c=1", bus.y, bus.y_hi, bus.flag_c); end
        step();
        issue(OP_MUL, 8'd255, 8'd255);
        checks++; if (bus.y !== 8'd1 || bus.y_hi !== 8'd254 || {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n} !== 4'b0100) begin failures++; $display("FAIL mul_max got y=%0d hi=%0d f=%b exp y=1 hi=254 f=0100", bus.y, bus.y_hi, {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}); end
        step();
    endtask

    task automatic test_div();
        int  lat;
        bit  ready_seen;
        lat = 0;
        ready_seen = 1'b0;
        issue(OP_DIV, 8'd200, 8'd7);
        checks++; if (dbg_state !== ST_DIV) begin failures++; $display("FAIL div_state got=%0d exp=%0d", dbg_state, ST_DIV); end
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) ready_seen = 1'b1;
            step();
            lat++;
        end
        checks++; if (lat != 8) begin failures++; $display("FAIL div_latency got=%0d exp=8", lat); end
        checks++; if (ready_seen || bus.in_ready !== 1'b0) begin failures++; $display("FAIL div_in_ready got seen=%0b now=%0b exp 0/0", ready_seen, bus.in_ready); end
        checks++; if (bus.y !== 8'd28 || bus.y_hi !== 8'd4 || bus.err !== 1'b0) begin failures++; $display("FAIL div_result got q=%0d r=%0d err=%0b exp q=28 r=4 err=0", bus.y, bus.y_hi, bus.err); end
        checks++; if ({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n} !== 4'b0000) begin failures++; $display("FAIL div_flags got=%b exp=0000", {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}); end
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL div_release got=%0b exp=1", bus.in_ready); end
        issue(OP_DIV, 8'd9, 8'd0);
        checks++; if (bus.out_valid !== 1'b1 || bus.y !== 8'd255 || bus.y_hi !== 8'd9 || bus.err !== 1'b1) begin failures++; $display("FAIL div_zero got vld=%0b y=%0d hi=%0d err=%0b exp 1/255/9/1", bus.out_valid, bus.y, bus.y_hi, bus.err); end
        checks++; if ({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n} !== 4'b0000) begin failures++; $display("FAIL div_zero_flags got=%b exp=0000", {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        issue(OP_XOR, 8'hF0, 8'hFF);
        checks++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h0F) begin failures++; $display("FAIL bp_first got vld=%0b y=%0h exp 1/0f", bus.out_valid, bus.y); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.op = OP_ADD; bus.a = 8'd1; bus.b = 8'd1; bus.in_valid = 1'b1;
            end
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h0F || bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cycle=%0d got vld=%0b y=%0h rdy=%0b exp 1/0f/0", i, bus.out_valid, bus.y, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got vld=%0b rdy=%0b exp 0/1", bus.out_valid, bus.in_ready); end
        repeat (3) step();
        checks++; if (bus.out_valid !== 1'b0 || bus.y !== 8'h0F) begin failures++; $display("FAIL bp_ignored got vld=%0b y=%0h exp 0/0f", bus.out_valid, bus.y); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   v_op[7]  = '{OP_ADD, OP_SUB, OP_OR, OP_NOT, OP_DIV, OP_AND, OP_XOR};
        logic [W-1:0] v_a[7]   = '{8'd7, 8'h10, 8'h0F, 8'h00, 8'd100, 8'hF0, 8'h3C};
        logic [W-1:0] v_b[7]   = '{8'd8, 8'h01, 8'h30, 8'h55, 8'd10, 8'h0F, 8'h3C};
        logic [W-1:0] v_exp[7] = '{8'd15, 8'h0F, 8'h3F, 8'hFF, 8'd10, 8'h00, 8'h00};
        logic [W-1:0] exp_y;
        int lat;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(v_exp[i]);
            issue(v_op[i], v_a[i], v_b[i]);
            wait_valid(20, lat);
            exp_y = exp_q.pop_front();
            checks++; if (bus.out_valid !== 1'b1 || bus.y !== exp_y) begin failures++; $display("FAIL b2b_%0d got vld=%0b y=%0h exp 1/%0h", i, bus.out_valid, bus.y, exp_y); end
            checks++; if (bus.flag_z !== (exp_y == 8'h00)) begin failures++; $display("FAIL b2b_z_%0d got=%0b exp=%0b", i, bus.flag_z, exp_y == 8'h00); end
            step();
        end
    endtask

    task automatic test_reset_mid_div();
        int vld_count;
        vld_count = 0;
        issue(OP_NOT, 8'h00, 8'h00);
        step();
        issue(OP_DIV, 8'd200, 8'd7);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.y !== 8'h00 || bus.y_hi !== 8'h00) begin failures++; $display("FAIL mid_rst_out got vld=%0b y=%0h hi=%0h exp 0/0/0", bus.out_valid, bus.y, bus.y_hi); end
        checks++; if ({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n, bus.err} !== 5'b0) begin failures++; $display("FAIL mid_rst_flags got=%b exp=00000", {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n, bus.err}); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL mid_rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%0b exp=1", bus.in_ready); end
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) vld_count++;
            step();
        end
        checks++; if (vld_count != 0) begin failures++; $display("FAIL mid_rst_stale got=%0d exp=0", vld_count); end
        issue(OP_AND, 8'hAA, 8'h0F);
        checks++; if (bus.out_valid !== 1'b1 || bus.y !== 8'h0A || bus.y_hi !== 8'h00) begin failures++; $display("FAIL mid_rst_and got vld=%0b y=%0h hi=%0h exp 1/0a/0", bus.out_valid, bus.y, bus.y_hi); end
        step();
    endtask

    // Sequence and final report.
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Keeps the same 3-bit opcode set and adds the following:
  - valid/ready handshakes on input and output
  - full-width multiply product
  - iterative multi-cycle divide with remainder
  - divide-by-zero error
  - status flags
- Sits between an operand/issue stage and a result writeback stage in datapath designs.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- op  input  3  opcode
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  primary result
- y_hi  output  WIDTH  product high half (MUL), remainder (DIV), else 0
- flag_z  output  1  y == 0
- flag_c  output  1  carry/borrow/overflow-out (see below)
- flag_v  output  1  signed overflow (ADD/SUB only)
- flag_n  output  1  y[WIDTH-1]
- err  output  1  divide by zero

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE
  - out_valid=0; y, y_hi and all flags = 0
  - divider registers cleared
- Reset asserted mid-divide aborts the operation; nothing is output.
- Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 NOT(a), 111 XOR.
- States:
  - IDLE: in_ready=1.
  - DIV: in_ready=0, divider iterating.
  - DONE: in_ready=0, out_valid=1.
- Accept: an operation is accepted on a clk edge where in_valid && in_ready. Operands and op are captured on that edge.
- Single-cycle ops (everything except DIV with b≠0):
  - Result is registered on the accept edge; IDLE→DONE.
  - out_valid=1 on the next cycle (latency 1).
- DIV with b≠0:
  - IDLE→DIV on accept. Restoring shift-subtract divide, one quotient bit per cycle, WIDTH iterations.
  - DIV→DONE after iteration WIDTH; out_valid is first seen WIDTH+1 cycles after accept.
- DIV with b=0: latency 1, y=all ones, y_hi=a, err=1, all other flags 0.
- DONE: outputs held stable until out_valid && out_ready, then DONE→IDLE. No new accept occurs in that same cycle (in_ready is 0 in DONE).
- Outputs change only on entry to DONE. out_valid drops the cycle after the output handshake; y, y_hi and flags keep their last values in IDLE/DIV.
- in_valid is ignored outside IDLE.
- Width rules:
  - ADD: y=(a+b) mod 2^WIDTH, flag_c=carry out.
  - SUB: y=(a-b) mod 2^WIDTH, flag_c=borrow (a<b).
  - flag_v (ADD/SUB only), signed two's-complement overflow:
    - ADD: a,b same sign and y sign differs.
    - SUB: a,b signs differ and y sign differs from a.
  - MUL: {y_hi,y}=a*b (2·WIDTH bits), flag_c=|y_hi.
  - DIV: y=quotient, y_hi=remainder.
  - Logic ops: y_hi=0.
- Flags for ops where they are not defined: flag_c=0 and flag_v=0. flag_z and flag_n are always computed from y.
- err=0 except for DIV by zero.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_XOR
  - state encoding ST_IDLE/ST_DIV/ST_DONE
- One sub-module: alu_div_iter, parametrised by WIDTH.
  - Interface: start, a, b → busy, done, quotient, remainder.
  - Implements the restoring divider.
  - alu_seq instantiates it and owns the handshake/FSM, single-cycle ops and flag logic.

Test Plan:
- WIDTH=8, ADD a=200 b=100, out_ready=1 → one cycle after accept:
  - y=44, y_hi=0
  - c=1, v=0, z=0, n=0
  - out_valid for exactly 1 cycle
- SUB a=5 b=7 → y=254, c=1, n=1, v=0. Then SUB a=0x80 b=0x01 → y=0x7F, v=1, c=0.
- MUL a=20 b=15 → y=44, y_hi=1, c=1. Then MUL a=255 b=255 → y=1, y_hi=254.
- DIV a=200 b=7 → in_ready=0 for 9 cycles after accept, then out_valid with y=28, y_hi=4, err=0. DIV a=9 b=0 → next cycle y=255, y_hi=9, err=1.
- Backpressure: XOR a=0xF0 b=0xFF with out_ready=0 for 5 cycles →
  - out_valid and y=0x0F held stable, in_ready=0 throughout
  - a second in_valid is ignored
  - after out_ready=1, in_ready=1 the following cycle
- Reset mid-divide: assert rst_n=0 at iteration 3 of a DIV →
  - out_valid/y/flags=0 immediately (asynchronously)
  - after release: in_ready=1, no stale result emitted
  - a following AND a=0xAA b=0x0F gives y=0x0A
